vga_scanout: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_gen.sv | 50 +++++
 rtl/vga_scanout.sv | 116 +++++++++++
 tb/tb_vga_scanout.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, colours and helpers for the VGA scan-out path.
package vga_timing_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FPORCH  = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BPORCH  = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;

   localparam int V_VISIBLE = 480;
   localparam int V_FPORCH  = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BPORCH  = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

   localparam int BYTES_PER_LINE = 80;
   localparam int CNT_W          = 10;
   localparam int ADDR_W         = 16;
   localparam int COLOR_W        = 12;

   localparam logic [COLOR_W-1:0] FG_COLOR = 12'hFFF;
   localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;

   typedef struct packed {
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] v;
   } scan_pos_t;

   function automatic logic [ADDR_W-1:0] line_addr(input logic [CNT_W-1:0] line,
                                                   input logic [CNT_W-1:0] col,
                                                   input int bpl);
      return ADDR_W'(int'(line) * bpl + int'(col));
   endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with combinational sync and visible decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VIS = H_VISIBLE,
   parameter int H_FP  = H_FPORCH,
   parameter int H_SW  = H_SYNC,
   parameter int H_BP  = H_BPORCH,
   parameter int V_VIS = V_VISIBLE,
   parameter int V_FP  = V_FPORCH,
   parameter int V_SW  = V_SYNC,
   parameter int V_BP  = V_BPORCH
)(
   input  logic      clock25,
   input  logic      reset_n,
   output scan_pos_t o_pos,
   output scan_pos_t o_pos_nxt,
   output logic      o_hsync_n,
   output logic      o_vsync_n,
   output logic      o_visible
);
   localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

   scan_pos_t r_pos;
   logic      w_h_wrap;
   logic      w_v_wrap;

   always_comb begin
      w_h_wrap  = (r_pos.h == CNT_W'(H_TOT - 1));
      w_v_wrap  = (r_pos.v == CNT_W'(V_TOT - 1));
      o_pos_nxt = r_pos;
      if (w_h_wrap) begin
         o_pos_nxt.h = '0;
         o_pos_nxt.v = w_v_wrap ? '0 : r_pos.v + 1'b1;
      end else begin
         o_pos_nxt.h = r_pos.h + 1'b1;
      end
   end

   always_ff @(posedge clock25) begin
      if (!reset_n) r_pos <= '0;
      else          r_pos <= o_pos_nxt;
   end

   assign o_pos     = r_pos;
   assign o_hsync_n = !((r_pos.h >= CNT_W'(H_VIS + H_FP)) && (r_pos.h < CNT_W'(H_VIS + H_FP + H_SW)));
   assign o_vsync_n = !((r_pos.v >= CNT_W'(V_VIS + V_FP)) && (r_pos.v < CNT_W'(V_VIS + V_FP + V_SW)));
   assign o_visible = (r_pos.h < CNT_W'(H_VIS)) && (r_pos.v < CNT_W'(V_VIS));
endmodule

// File: rtl/vga_scanout.sv
// 1-bpp frame-buffer fetch, pixel serialiser and registered VGA outputs.
// Optional VGA_SCANOUT_BORDER_EN forces the outermost visible rows/columns to FG_COLOR.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_VIS = H_VISIBLE,
   parameter int H_FP  = H_FPORCH,
   parameter int H_SW  = H_SYNC,
   parameter int H_BP  = H_BPORCH,
   parameter int V_VIS = V_VISIBLE,
   parameter int V_FP  = V_FPORCH,
   parameter int V_SW  = V_SYNC,
   parameter int V_BP  = V_BPORCH
)(
   input  logic              clock25,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [0:7]        rd_data,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_tick
);
   localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
   localparam int BPL   = H_VIS / 8;

   scan_pos_t w_pos, w_nxt;
   logic      w_hsync_n, w_vsync_n, w_visible;

   vga_timing_gen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
   ) u_timing (
      .clock25   (clock25),
      .reset_n   (reset_n),
      .o_pos     (w_pos),
      .o_pos_nxt (w_nxt),
      .o_hsync_n (w_hsync_n),
      .o_vsync_n (w_vsync_n),
      .o_visible (w_visible)
   );

   // Fetch is decoded from the next counter value so the registered strobe
   // lines up with the cycle the counter holds the fetch slot.
   logic             w_line_end, w_fetch;
   logic [CNT_W-1:0] w_line, w_col, w_h_p2;

   always_comb begin
      w_h_p2     = w_nxt.h + CNT_W'(2);
      w_line_end = (w_nxt.h == CNT_W'(H_TOT - 2));
      w_line     = w_nxt.v;
      w_col      = w_h_p2 >> 3;
      if (w_line_end) begin
         w_col  = '0;
         w_line = (w_nxt.v == CNT_W'(V_TOT - 1)) ? '0 : w_nxt.v + 1'b1;
      end
      w_fetch = (w_nxt.h[2:0] == 3'd6) && (w_line < CNT_W'(V_VIS)) && (w_col < CNT_W'(BPL));
   end

   logic [0:7]         r_shreg;
   logic               r_primed;
   logic [COLOR_W-1:0] r_rgb;
   logic               r_hsync, r_vsync, r_tick, r_rd_en;
   logic [ADDR_W-1:0]  r_rd_addr;
   logic               w_pix_on, w_border, w_wrap;
   logic [COLOR_W-1:0] w_rgb;

   always_comb begin
      w_pix_on = r_shreg[w_pos.h[2:0]];
`ifdef VGA_SCANOUT_BORDER_EN
      w_border = (w_pos.h == '0) || (w_pos.h == CNT_W'(H_VIS - 1)) ||
                 (w_pos.v == '0) || (w_pos.v == CNT_W'(V_VIS - 1));
`else
      w_border = 1'b0;
`endif
      w_wrap = (w_pos.h == CNT_W'(H_TOT - 1)) && (w_pos.v == CNT_W'(V_TOT - 1));
      w_rgb  = '0;
      // Until the first full frame has been fetched, line 0 byte 0 holds stale data.
      if (w_visible && r_primed) w_rgb = (w_pix_on || w_border) ? FG_COLOR : BG_COLOR;
   end

   always_ff @(posedge clock25) begin
      if (!reset_n) begin
         r_shreg   <= '0;
         r_primed  <= 1'b0;
         r_rgb     <= '0;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_tick    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         r_rgb   <= w_rgb;
         r_hsync <= w_hsync_n;
         r_vsync <= w_vsync_n;
         r_tick  <= (w_pos.h == '0) && (w_pos.v == CNT_W'(V_VIS));
         if (w_pos.h[2:0] == 3'd7) r_shreg <= rd_data;
         if (w_wrap) r_primed <= 1'b1;
         r_rd_en <= w_fetch;
         if (w_fetch) r_rd_addr <= line_addr(w_line, w_col, BPL);
      end
   end

   assign rd_en      = r_rd_en;
   assign rd_addr    = r_rd_addr;
   assign red        = r_rgb[11:8];
   assign green      = r_rgb[7:4];
   assign blue       = r_rgb[3:0];
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign frame_tick = r_tick;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench: full-geometry instance checked over its first lines, reduced-geometry instance
// checked over whole frames against an arithmetic model of the scan rules.
`timescale 1ns/1ps
module tb_vga_scanout;
   localparam int S_HV = 64, S_HF = 8, S_HS = 16, S_HB = 8;
   localparam int S_VV = 12, S_VF = 2, S_VS = 2,  S_VB = 4;
   localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
   localparam int S_F  = S_HT * S_VT;
   localparam int S_BPL = S_HV / 8;
   localparam int S_MEM = S_VV * S_BPL;

   logic clock25 = 1'b0;
   always #20 clock25 = ~clock25;

   logic        rst_s_n, rst_d_n;
   logic [15:0] s_rd_addr, d_rd_addr;
   logic        s_rd_en, d_rd_en;
   logic [0:7]  s_rd_data, d_rd_data;
   logic [3:0]  s_r, s_g, s_b, d_r, d_g, d_b;
   logic        s_hs, s_vs, s_ft, d_hs, d_vs, d_ft;

   logic [7:0] mem [0:S_MEM-1];

   vga_scanout #(
      .H_VIS(S_HV), .H_FP(S_HF), .H_SW(S_HS), .H_BP(S_HB),
      .V_VIS(S_VV), .V_FP(S_VF), .V_SW(S_VS), .V_BP(S_VB)
   ) dut_s (
      .clock25(clock25), .reset_n(rst_s_n), .rd_addr(s_rd_addr), .rd_en(s_rd_en),
      .rd_data(s_rd_data), .red(s_r), .green(s_g), .blue(s_b),
      .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
   );

   vga_scanout dut_d (
      .clock25(clock25), .reset_n(rst_d_n), .rd_addr(d_rd_addr), .rd_en(d_rd_en),
      .rd_data(d_rd_data), .red(d_r), .green(d_g), .blue(d_b),
      .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
   );

   // Synchronous-read RAM with one cycle of latency; holds its output when not read.
   initial s_rd_data = 8'h00;
   always @(posedge clock25) if (s_rd_en) s_rd_data <= mem[s_rd_addr];
   initial d_rd_data = 8'hFF;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   logic [15:0] s_exp_addr, d_exp_addr;
   int d_hs_low, s_ticks;

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // {rd_en, rd_addr} issued while the scan position is c (rd_addr 0 when no fetch).
   function automatic logic [16:0] fetch_model(input int ht, input int vt, input int vvis,
                                               input int bpl, input int c);
      int h, v, line, col;
      h = c % ht;
      v = (c / ht) % vt;
      if (h % 8 != 6) return 17'h0;
      if (h == ht - 2) begin
         line = (v + 1) % vt;
         col  = 0;
      end else begin
         line = v;
         col  = (h + 2) / 8;
      end
      if (line >= vvis || col >= bpl) return 17'h0;
      return {1'b1, 16'(line * bpl + col)};
   endfunction

   // {hsync, vsync, frame_tick} for scan position c.
   function automatic logic [2:0] sync_model(input int hvis, input int hfp, input int hsw, input int hbp,
                                             input int vvis, input int vfp, input int vsw, input int vbp,
                                             input int c);
      int ht, vt, h, v;
      ht = hvis + hfp + hsw + hbp;
      vt = vvis + vfp + vsw + vbp;
      h = c % ht;
      v = (c / ht) % vt;
      return {!(h >= hvis + hfp && h < hvis + hfp + hsw),
              !(v >= vvis + vfp && v < vvis + vfp + vsw),
              (h == 0 && v == vvis)};
   endfunction

   function automatic logic [11:0] rgb_model(input int c, input bit primed);
      int h, v;
      logic [7:0] b;
      h = c % S_HT;
      v = (c / S_HT) % S_VT;
      if (!primed || h >= S_HV || v >= S_VV) return 12'h000;
`ifdef VGA_SCANOUT_BORDER_EN
      if (h == 0 || h == S_HV - 1 || v == 0 || v == S_VV - 1) return 12'hFFF;
`endif
      b = mem[v * S_BPL + h / 8];
      return b[7 - (h % 8)] ? 12'hFFF : 12'h000;
   endfunction

   task automatic step_small(input int k);
      logic [16:0] f;
      check("s_out", k, {17'h0, s_r, s_g, s_b, s_hs, s_vs, s_ft},
            {17'h0, rgb_model(k - 1, (k - 1) >= S_F),
             sync_model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, k - 1)});
      f = fetch_model(S_HT, S_VT, S_VV, S_BPL, k);
      if (f[16]) s_exp_addr = f[15:0];
      check("s_fetch", k, {15'h0, s_rd_en, s_rd_addr}, {15'h0, f[16], s_exp_addr});
   endtask

   task automatic step_default(input int k);
      logic [16:0] f;
      check("d_out", k, {17'h0, d_r, d_g, d_b, d_hs, d_vs, d_ft},
            {17'h0, 12'h000, sync_model(640, 16, 96, 48, 480, 10, 2, 33, k - 1)});
      f = fetch_model(800, 525, 480, 80, k);
      if (f[16]) d_exp_addr = f[15:0];
      check("d_fetch", k, {15'h0, d_rd_en, d_rd_addr}, {15'h0, f[16], d_exp_addr});
   endtask

   initial begin
      rst_s_n = 1'b0;
      rst_d_n = 1'b0;
      foreach (mem[i]) mem[i] = 8'($urandom);
      mem[0]         = 8'h80;
      mem[S_MEM - 1] = 8'h01;
      repeat (3) @(posedge clock25);
      @(negedge clock25);
      check("s_reset_out",   0, {17'h0, s_r, s_g, s_b, s_hs, s_vs, s_ft}, {17'h0, 12'h000, 3'b110});
      check("s_reset_fetch", 0, {15'h0, s_rd_en, s_rd_addr}, 32'h0);
      check("d_reset_out",   0, {17'h0, d_r, d_g, d_b, d_hs, d_vs, d_ft}, {17'h0, 12'h000, 3'b110});
      check("d_reset_fetch", 0, {15'h0, d_rd_en, d_rd_addr}, 32'h0);
      rst_s_n = 1'b1;
      rst_d_n = 1'b1;
      s_exp_addr = '0;
      d_exp_addr = '0;
      d_hs_low = 0;
      s_ticks = 0;

      // Two full frames plus part of a third, stopping while the counter holds (30,5).
      for (int k = 1; k <= 2 * S_F + 5 * S_HT + 30; k++) begin
         @(posedge clock25);
         @(negedge clock25);
         step_small(k);
         if (k <= 2000) step_default(k);
         if (k <= 800 && !d_hs) d_hs_low++;
         if (k <= 2 * S_F && s_ft) s_ticks++;
      end
      check("d_hsync_width", 0, 32'(d_hs_low), 32'd96);
      check("s_ticks_2frames", 0, 32'(s_ticks), 32'd2);

      // One-cycle reset mid-frame, then fresh RAM contents.
      rst_s_n = 1'b0;
      @(posedge clock25);
      @(negedge clock25);
      check("s_midreset_out",   0, {17'h0, s_r, s_g, s_b, s_hs, s_vs, s_ft}, {17'h0, 12'h000, 3'b110});
      check("s_midreset_fetch", 0, {15'h0, s_rd_en, s_rd_addr}, 32'h0);
      foreach (mem[i]) mem[i] = 8'($urandom);
      rst_s_n = 1'b1;
      s_exp_addr = '0;
      for (int k = 1; k <= 2 * S_F + 100; k++) begin
         @(posedge clock25);
         @(negedge clock25);
         step_small(k);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
